register_seq_ctrl: RTL and testbench
====================================

Name: register_seq_ctrl

Overview:
- Parametrised row-write sequencer for the register bank.
- On a store request it issues a burst of consecutive row writes. Start row, row count and stride are programmable. Write data comes from either a row-address tag or an external data input.
- Supports back-pressure from the bank (bank_ready) and mid-burst abort.
- Sits between the memory/state controller and the register bank write port.

Parameters:
ADDR_W, 4, row address width
DATA_W, 16, write data width (must be >= ADDR_W)
MAX_ROWS, 16, maximum rows per burst; larger requests are clamped
STRIDE, 1, row address increment per beat
DATA_MODE, 0, 0: sw2_out = row address zero-extended to DATA_W; 1: sw2_out = wr_data_in sampled per beat
(localparam CNT_W = clog2(MAX_ROWS+1))

Ports:
clk  in  1  clock; all state and outputs update on the falling edge (bank samples on the rising edge)
rst  in  1  synchronous active-high reset, sampled on the falling edge of clk
state_ctrl_store  in  1  burst start request, sampled in IDLE only
start_addr  in  ADDR_W  first row, latched at start
row_count  in  CNT_W  rows to write, latched at start
bank_ready  in  1  bank accepts the current beat
wr_data_in  in  DATA_W  external write data (DATA_MODE=1)
abort  in  1  terminate burst early
rowaddr  out  ADDR_W  row address to bank
sw2_out  out  DATA_W  write data to bank
writemem  out  1  write strobe
busy  out  1  high from the start edge until the DONE edge inclusive
state_ctrl_done  out  1  one-cycle completion pulse
aborted  out  1  last burst ended by abort; held until next start
beats_written  out  CNT_W  beats accepted in the last burst; held until next start

Behaviour:
- Reset values: rowaddr=0, sw2_out=0, writemem=0, busy=0, state_ctrl_done=0, aborted=0, beats_written=0, state=IDLE. Reset overrides everything, including mid-burst; no further writes follow.
- FSM states are IDLE, WRITE and DONE.
- Encoding: 2-bit; the unused code returns to IDLE with writemem=0.
- IDLE:
  - writemem=0 and state_ctrl_done=0.
  - On an edge with state_ctrl_store=1 and row_count!=0: latch N=min(row_count,MAX_ROWS); clear aborted and beats_written.
  - On that same edge drive rowaddr=start_addr, sw2_out per DATA_MODE and writemem=1. Set busy=1 and go to WRITE.
  - With state_ctrl_store=1 and row_count=0: go directly to DONE with no write. beats_written=0 and aborted=0.
- WRITE:
  - A beat is accepted at an edge where writemem=1 and bank_ready=1. On acceptance, beats_written increments.
  - If beats remain, rowaddr advances by STRIDE modulo 2^ADDR_W (wrap-around is silent), and sw2_out is updated.
  - On acceptance of the last beat: go to DONE with writemem=0.
  - If bank_ready=0: hold rowaddr, sw2_out and writemem unchanged (stall, unbounded).
  - In DATA_MODE=1, sw2_out for each beat is wr_data_in sampled at the edge that presents that beat.
- abort=1 in WRITE:
  - Go to DONE with writemem=0 and aborted=1.
  - If bank_ready=1 on the same edge, that beat counts as accepted before stopping.
  - If that was also the last beat, aborted=0 (normal completion wins).
- DONE:
  - state_ctrl_done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
  - state_ctrl_store is ignored in WRITE and DONE; it is never queued.
- Latency: with bank_ready tied high, the store edge is followed by N cycles of writemem high (edges 0..N-1), a done pulse at edge N, and idle at edge N+1.
- abort in IDLE or DONE has no effect.

Decomposition:
- Shared package reg_ctrl_pkg holds:
  - state enum (IDLE/WRITE/DONE)
  - DATA_MODE constants (MODE_TAG=0, MODE_EXT=1)
  - the clog2 helper function
- One natural sub-module, row_addr_gen: latches the start address and remaining count, and produces the next address, last-beat flag and wrap.
- The FSM and output registers stay in the top module.

Test Plan:
- Defaults, start_addr=8, row_count=4, bank_ready=1: writes rows 8,9,10,11 with sw2_out=0x0008..0x000B on 4 consecutive cycles, then state_ctrl_done pulse, beats_written=4.
- start_addr=14, STRIDE=1, row_count=4: rows 14,15,0,1 (wrap), done after 4 beats.
- row_count=4, bank_ready low for 3 cycles during row 9: rowaddr holds 9 with writemem=1 for 4 cycles, then 10,11; done pulse once, beats_written=4.
- row_count=6, abort with bank_ready=1 on the 3rd beat: 3 writes, aborted=1, beats_written=3, single done pulse, no further writemem.
- row_count=0 -> done pulse next cycle, writemem never high. row_count=20 with MAX_ROWS=16 -> exactly 16 writes.
- rst asserted during beat 2 -> writemem=0 and all outputs zero on that edge; store during busy is ignored; DATA_MODE=1 with wr_data_in=0xA5A5,0x1234 -> sw2_out matches per beat.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctrl_pkg
// Description : Shared types, data-mode codes and helpers for the register
//               bank row-write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int MODE_TAG = 0;
    localparam int MODE_EXT = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_seq_ctrl_row_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : row_addr_gen
// Description : Holds the current row and beats remaining for a burst and
//               supplies the next row address and last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module row_addr_gen #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              advance,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last_beat
);

    localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(STRIDE);

    logic [ADDR_W-1:0] r_cur_addr;
    logic [CNT_W-1:0]  r_remaining;

    // Truncation to ADDR_W gives the silent modulo wrap of the row space.
    assign next_addr = r_cur_addr + C_STRIDE;
    assign last_beat = (r_remaining == CNT_W'(1));

    always_ff @(negedge clk) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else if (load) begin
            r_cur_addr  <= start_addr;
            r_remaining <= count;
        end else if (advance) begin
            r_cur_addr  <= next_addr;
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : register_seq_ctrl
// Description : Row-write burst sequencer for the register bank, with
//               back-pressure, abort and falling-edge output timing.
// Revision    : 1.0 - initial release
// ============================================================================
module register_seq_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int  ADDR_W    = 4,
    parameter int  DATA_W    = 16,
    parameter int  MAX_ROWS  = 16,
    parameter int  STRIDE    = 1,
    parameter int  DATA_MODE = MODE_TAG,
    localparam int CNT_W     = clog2(MAX_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              state_ctrl_store,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  row_count,
    input  logic              bank_ready,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              abort,
    output logic [ADDR_W-1:0] rowaddr,
    output logic [DATA_W-1:0] sw2_out,
    output logic              writemem,
    output logic              busy,
    output logic              state_ctrl_done,
    output logic              aborted,
    output logic [CNT_W-1:0]  beats_written
);

    localparam logic [CNT_W-1:0] C_MAX_ROWS = CNT_W'(MAX_ROWS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rowaddr;
    logic [DATA_W-1:0] r_sw2;
    logic              r_writemem;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [CNT_W-1:0]  r_beats;

    state_t            w_state_next;
    logic [ADDR_W-1:0] w_rowaddr_next;
    logic [DATA_W-1:0] w_sw2_next;
    logic              w_writemem_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_aborted_next;
    logic [CNT_W-1:0]  w_beats_next;
    logic              w_load;
    logic              w_advance;
    logic              w_accept;
    logic [CNT_W-1:0]  w_count_clamped;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_last_beat;
    logic [DATA_W-1:0] w_data_first;
    logic [DATA_W-1:0] w_data_step;

    assign w_count_clamped = (row_count > C_MAX_ROWS) ? C_MAX_ROWS : row_count;
    assign w_accept        = r_writemem && bank_ready;

    row_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .STRIDE (STRIDE)
    ) u_row_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .start_addr (start_addr),
        .count      (w_count_clamped),
        .advance    (w_advance),
        .next_addr  (w_next_addr),
        .last_beat  (w_last_beat)
    );

    generate
        if (DATA_MODE == MODE_EXT) begin : g_data_ext
            assign w_data_first = wr_data_in;
            assign w_data_step  = wr_data_in;
        end else begin : g_data_tag
            logic w_unused_data;
            assign w_unused_data = ^wr_data_in;
            assign w_data_first  = DATA_W'(start_addr);
            assign w_data_step   = DATA_W'(w_next_addr);
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_rowaddr_next  = r_rowaddr;
        w_sw2_next      = r_sw2;
        w_writemem_next = r_writemem;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_aborted_next  = r_aborted;
        w_beats_next    = r_beats;
        w_load          = 1'b0;
        w_advance       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_writemem_next = 1'b0;
                w_busy_next     = 1'b0;
                if (state_ctrl_store) begin
                    w_aborted_next = 1'b0;
                    w_beats_next   = '0;
                    w_busy_next    = 1'b1;
                    if (row_count != '0) begin
                        w_load          = 1'b1;
                        w_rowaddr_next  = start_addr;
                        w_sw2_next      = w_data_first;
                        w_writemem_next = 1'b1;
                        w_state_next    = ST_WRITE;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end

            ST_WRITE: begin
                if (w_accept) begin
                    w_beats_next = r_beats + CNT_W'(1);
                    w_advance    = 1'b1;
                end
                // Completing the final beat outranks a simultaneous abort.
                if (w_accept && w_last_beat) begin
                    w_writemem_next = 1'b0;
                    w_done_next     = 1'b1;
                    w_state_next    = ST_DONE;
                end else if (abort) begin
                    w_writemem_next = 1'b0;
                    w_done_next     = 1'b1;
                    w_aborted_next  = 1'b1;
                    w_state_next    = ST_DONE;
                end else if (w_accept) begin
                    w_rowaddr_next = w_next_addr;
                    w_sw2_next     = w_data_step;
                end
            end

            ST_DONE: begin
                w_writemem_next = 1'b0;
                w_busy_next     = 1'b0;
                w_state_next    = ST_IDLE;
            end

            default: begin
                w_writemem_next = 1'b0;
                w_busy_next     = 1'b0;
                w_state_next    = ST_IDLE;
            end
        endcase
    end

    // The bank samples on the rising edge, so everything here moves on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rowaddr  <= '0;
            r_sw2      <= '0;
            r_writemem <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_beats    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rowaddr  <= w_rowaddr_next;
            r_sw2      <= w_sw2_next;
            r_writemem <= w_writemem_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_aborted  <= w_aborted_next;
            r_beats    <= w_beats_next;
        end
    end

    assign rowaddr         = r_rowaddr;
    assign sw2_out         = r_sw2;
    assign writemem        = r_writemem;
    assign busy            = r_busy;
    assign state_ctrl_done = r_done;
    assign aborted         = r_aborted;
    assign beats_written   = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_register_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_seq_ctrl
// Description : Directed and random bench for register_seq_ctrl, with one
//               instance per data mode checked against a beat-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_seq_ctrl;
    import reg_ctrl_pkg::*;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int MAX_ROWS = 16;
    localparam int STRIDE   = 1;
    localparam int CNT_W    = clog2(MAX_ROWS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              store;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  row_count;
    logic              bank_ready;
    logic [DATA_W-1:0] wr_data_in;
    logic              abort;

    logic [ADDR_W-1:0] rowaddr,  x_rowaddr;
    logic [DATA_W-1:0] sw2_out,  x_sw2_out;
    logic              writemem, x_writemem;
    logic              busy,     x_busy;
    logic              done,     x_done;
    logic              aborted,  x_aborted;
    logic [CNT_W-1:0]  beats,    x_beats;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    // Reference model: phase 0 idle, 1 writing, 2 done.
    int                m_phase = 0;
    int                m_n, m_idx, m_sa, m_beats;
    bit                m_ab;
    logic [ADDR_W-1:0] m_rowaddr;
    logic [DATA_W-1:0] m_data;

    always #5 clk = ~clk;

    register_seq_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ROWS(MAX_ROWS),
        .STRIDE(STRIDE), .DATA_MODE(MODE_TAG)
    ) dut (
        .clk(clk), .rst(rst), .state_ctrl_store(store), .start_addr(start_addr),
        .row_count(row_count), .bank_ready(bank_ready), .wr_data_in(wr_data_in),
        .abort(abort), .rowaddr(rowaddr), .sw2_out(sw2_out), .writemem(writemem),
        .busy(busy), .state_ctrl_done(done), .aborted(aborted), .beats_written(beats)
    );

    register_seq_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ROWS(MAX_ROWS),
        .STRIDE(STRIDE), .DATA_MODE(MODE_EXT)
    ) dut_ext (
        .clk(clk), .rst(rst), .state_ctrl_store(store), .start_addr(start_addr),
        .row_count(row_count), .bank_ready(bank_ready), .wr_data_in(wr_data_in),
        .abort(abort), .rowaddr(x_rowaddr), .sw2_out(x_sw2_out), .writemem(x_writemem),
        .busy(x_busy), .state_ctrl_done(x_done), .aborted(x_aborted), .beats_written(x_beats)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = 0; m_rowaddr = '0; m_data = '0; m_beats = 0; m_ab = 0;
        end else begin
            case (m_phase)
                0: if (store) begin
                    m_beats = 0;
                    m_ab    = 0;
                    if (row_count != 0) begin
                        m_n       = (int'(row_count) > MAX_ROWS) ? MAX_ROWS : int'(row_count);
                        m_sa      = int'(start_addr);
                        m_idx     = 0;
                        m_rowaddr = start_addr;
                        m_data    = wr_data_in;
                        m_phase   = 1;
                    end else begin
                        m_phase = 2;
                    end
                end
                1: begin
                    if (bank_ready) m_beats++;
                    if (bank_ready && m_beats == m_n) begin
                        m_phase = 2;
                    end else if (abort) begin
                        m_phase = 2;
                        m_ab    = 1;
                    end else if (bank_ready) begin
                        m_idx++;
                        m_rowaddr = ADDR_W'((m_sa + m_idx * STRIDE) % (1 << ADDR_W));
                        m_data    = wr_data_in;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("writemem", 32'(writemem), 32'(m_phase == 1));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("done",     32'(done),     32'(m_phase == 2));
        chk("aborted",  32'(aborted),  32'(m_ab));
        chk("beats",    32'(beats),    32'(m_beats));
        chk("rowaddr",  32'(rowaddr),  32'(m_rowaddr));
        chk("sw2_tag",  32'(sw2_out),  32'(m_rowaddr));
        chk("x_writemem", 32'(x_writemem), 32'(m_phase == 1));
        chk("x_busy",     32'(x_busy),     32'(m_phase != 0));
        chk("x_done",     32'(x_done),     32'(m_phase == 2));
        chk("x_aborted",  32'(x_aborted),  32'(m_ab));
        chk("x_beats",    32'(x_beats),    32'(m_beats));
        chk("x_rowaddr",  32'(x_rowaddr),  32'(m_rowaddr));
        chk("sw2_ext",    32'(x_sw2_out),  32'(m_data));
    endtask

    // One falling (active) edge, then sample on the following rising edge.
    task automatic tick();
        if (!rst && writemem === 1'b1 && bank_ready) wr_cnt++;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        check_all();
    endtask

    task automatic start(input int sa, input int rc);
        store      = 1'b1;
        start_addr = ADDR_W'(sa);
        row_count  = CNT_W'(rc);
        tick();
        store = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            wr_data_in = DATA_W'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; store = 1'b0; start_addr = '0; row_count = '0;
        bank_ready = 1'b1; wr_data_in = '0; abort = 1'b0;
        @(posedge clk);
        tick();
        tick();
        chk("reset_writemem", 32'(writemem), 32'd0);
        chk("reset_rowaddr",  32'(rowaddr),  32'd0);
        rst = 1'b0;
        idle(2);

        // Basic burst and data-mode sampling.
        wr_data_in = 16'hA5A5;
        start(8, 4);
        chk("first_row", 32'(rowaddr), 32'd8);
        chk("first_ext", 32'(x_sw2_out), 32'hA5A5);
        wr_data_in = 16'h1234;
        tick();
        chk("second_ext", 32'(x_sw2_out), 32'h1234);
        idle(5);
        chk("beats_after_burst", 32'(beats), 32'd4);

        // Address wrap.
        start(14, 4);
        idle(6);

        // Back-pressure during row 9.
        start(8, 4);
        tick();
        bank_ready = 1'b0;
        idle(3);
        chk("stall_hold_row", 32'(rowaddr), 32'd9);
        bank_ready = 1'b1;
        idle(5);

        // Abort on the third accepted beat.
        start(2, 6);
        idle(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_flag",  32'(aborted), 32'd1);
        chk("abort_beats", 32'(beats),   32'd3);
        idle(3);

        // Abort coinciding with the last beat completes normally.
        start(5, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_last_flag", 32'(aborted), 32'd0);
        idle(2);

        // Zero-length and clamped bursts.
        wr_cnt = 0;
        start(3, 0);
        chk("zero_done", 32'(done), 32'd1);
        idle(2);
        chk("zero_writes", 32'(wr_cnt), 32'd0);
        wr_cnt = 0;
        start(1, 20);
        idle(20);
        chk("clamp_writes", 32'(wr_cnt), 32'd16);

        // Reset mid-burst.
        start(0, 6);
        idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // Store held high during a burst is not queued.
        store = 1'b1; start_addr = 4'd4; row_count = 5'd3;
        tick();
        row_count = 5'd7;
        idle(4);
        store = 1'b0;
        idle(10);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            store      = ($urandom_range(0, 9) == 0);
            start_addr = ADDR_W'($urandom);
            row_count  = CNT_W'($urandom_range(0, 20));
            bank_ready = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 19) == 0);
            wr_data_in = DATA_W'($urandom);
            tick();
        end
        rst = 1'b0; store = 1'b0; abort = 1'b0; bank_ready = 1'b1;
        idle(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
